// File: rtl/mem_access_ctrl.sv
// Four-state SRAM access sequencer (IDLE/SETUP/ACCESS/DONE) with a programmable ACCESS wait count.
// Optional MEM_WRITE_PROTECT_EN: writes into 0xFE00-0xFFFF run the full sequence but never strobe WE or drive the bus.
//
// state  | meaning
// IDLE   | waiting for Req; request fields captured on acceptance
// SETUP  | address and chip enables applied, WE held high
// ACCESS | WAIT_CYCLES cycles of OE (read) or WE (write) low
// DONE   | one-cycle Ready pulse, strobes released, ADDR held
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        RW,
  input  logic [15:0] Addr_in,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Ready,
  output logic        Busy,
  output logic [15:0] ADDR,
  inout  wire  [15:0] Data_Mem,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;

  logic        wr_blocked;
  logic        wr_en;
  logic        bus_drive;
  logic        ce_c, ub_c, lb_c, oe_c, we_c;
  logic        ready_c, busy_c;

`ifdef MEM_WRITE_PROTECT_EN
  assign wr_blocked = (addr_q[15:9] == 7'h7F);
`else
  assign wr_blocked = 1'b0;
`endif

  // A blocked write still walks through every state so the CPU sees normal timing.
  assign wr_en = rw_q & ~wr_blocked;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    ce_c      = 1'b1;
    ub_c      = 1'b1;
    lb_c      = 1'b1;
    oe_c      = 1'b1;
    we_c      = 1'b1;
    ready_c   = 1'b0;
    busy_c    = 1'b1;
    bus_drive = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (Req) begin
          addr_d  = Addr_in;
          wdata_d = Data_in;
          rw_d    = RW;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        ce_c      = 1'b0;
        ub_c      = 1'b0;
        lb_c      = 1'b0;
        oe_c      = rw_q;
        bus_drive = wr_en;
        cnt_d     = CNT_LOAD;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        ce_c      = 1'b0;
        ub_c      = 1'b0;
        lb_c      = 1'b0;
        oe_c      = rw_q;
        we_c      = ~wr_en;
        bus_drive = wr_en;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!rw_q) begin
            dout_d = Data_Mem;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        ready_c   = 1'b1;
        bus_drive = wr_en;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q    <= 1'b0;
      cnt_q   <= 4'd0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign Data_Mem = bus_drive ? wdata_q : 16'hzzzz;
  assign Data_out = dout_q;
  assign ADDR     = addr_q;
  assign Ready    = ready_c;
  assign Busy     = busy_c;
  assign CE       = ce_c;
  assign UB       = ub_c;
  assign LB       = lb_c;
  assign OE       = oe_c;
  assign WE       = we_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a simple asynchronous SRAM model on the shared data bus.
// Honours MEM_WRITE_PROTECT_EN when predicting writes into the I/O region.
module tb_mem_access_ctrl;

  localparam int W = 2;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_b;
  logic        req;
  logic        rw;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        ready;
  logic        busy;
  logic [15:0] addr;
  wire  [15:0] data_mem;
  logic        ce, ub, lb, oe, we;

  logic [15:0] mem [0:65535];

  mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk      (clk),
    .Reset    (rst_b),
    .Req      (req),
    .RW       (rw),
    .Addr_in  (addr_in),
    .Data_in  (data_in),
    .Data_out (data_out),
    .Ready    (ready),
    .Busy     (busy),
    .ADDR     (addr),
    .Data_Mem (data_mem),
    .CE       (ce),
    .UB       (ub),
    .LB       (lb),
    .OE       (oe),
    .WE       (we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: drives on read strobes; a write abandoned by reset is not committed.
  assign data_mem = (!ce && !oe && we) ? mem[addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce && !we && rst_b) mem[addr] <= data_mem;
  end

  typedef struct {
    logic        rw;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] val;
    int          exp_cyc;
  } sb_t;

  sb_t  sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   oe_cnt = 0;
  int   we_cnt = 0;
  int   rdy_prev_cyc = -1;
  int   rdy_last_cyc = -1;
  logic prev_ready = 1'b0;
  logic mon_en = 1'b0;
  logic [15:0] dout_model = 16'h0000;
  logic [15:0] wd [0:4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic prot(input logic [15:0] a);
    return PROT_EN && (a[15:9] == 7'h7F);
  endfunction

  task automatic monitor();
    sb_t e;
    if (!busy) begin
      oe_cnt = 0;
      we_cnt = 0;
    end
    if (!ce && !oe) oe_cnt++;
    if (!we) we_cnt++;
    if (sb.size() > 0 && busy && sb[0].rw && !prot(sb[0].a))
      chk("wr_bus", 32'(data_mem), 32'(sb[0].d));
    if (prev_ready) chk("ready_one_cycle", 32'(ready), 32'd0);
    if (ready) begin
      rdy_prev_cyc = rdy_last_cyc;
      rdy_last_cyc = cyc;
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.exp_cyc));
        chk("done_addr", 32'(addr), 32'(e.a));
        if (!e.rw) begin
          chk("rd_data", 32'(data_out), 32'(e.val));
          chk("rd_oe_cycles", 32'(oe_cnt), 32'(W + 1));
          chk("rd_we_cycles", 32'(we_cnt), 32'd0);
          dout_model = e.val;
        end else begin
          chk("wr_mem", 32'(mem[e.a]), 32'(e.val));
          chk("wr_dout_kept", 32'(data_out), 32'(dout_model));
          chk("wr_we_cycles", 32'(we_cnt), prot(e.a) ? 32'd0 : 32'(W));
          chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        end
      end
    end
    prev_ready = ready;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (mon_en) monitor();
  endtask

  task automatic push(input logic r, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] v, input int ec);
    sb_t e;
    e.rw = r; e.a = a; e.d = d; e.val = v; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && sb.size() > 0; k++) cycle();
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    cycle();
  endtask

  task automatic idle_checks(input logic [15:0] a);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(ready), 32'd0);
    chk("idle_strobes", 32'({ce, ub, lb, oe, we}), 32'h1F);
    chk("idle_addr_hold", 32'(addr), 32'(a));
  endtask

  // Called at a negedge with the DUT idle; junk on the inputs after acceptance must be ignored.
  task automatic do_access(input logic r, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] v);
    req = 1'b1; rw = r; addr_in = a; data_in = d;
    push(r, a, d, v, cyc + 2 + W);
    cycle();
    req = 1'b0; rw = ~r; addr_in = 16'($urandom); data_in = 16'($urandom);
    wait_idle();
    idle_checks(a);
  endtask

  initial begin
    int start;
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    mem[16'h0010] <= 16'h1234;
    mem[16'h0001] <= 16'h1111;
    mem[16'h0002] <= 16'h2222;
    mem[16'h0030] <= 16'h3030;
    mem[16'hFFFE] <= 16'hCAFE;
    rst_b = 1'b0; req = 1'b0; rw = 1'b0; addr_in = 16'h0000; data_in = 16'h0000;
    repeat (3) cycle();
    mon_en = 1'b1;
    cycle();
    chk("rst_dout", 32'(data_out), 32'h0000);
    idle_checks(16'h0000);
    rst_b = 1'b1;
    cycle();

    do_access(1'b0, 16'h0010, 16'h0000, 16'h1234);
    do_access(1'b1, 16'h0020, 16'hBEEF, 16'hBEEF);
    chk("dout_after_write", 32'(data_out), 32'h1234);
    do_access(1'b0, 16'h0020, 16'h0000, 16'hBEEF);

    // Back-to-back reads with Req held; Addr_in moves during the first ACCESS.
    start = cyc;
    req = 1'b1; rw = 1'b0; addr_in = 16'h0001;
    push(1'b0, 16'h0001, 16'h0000, 16'h1111, start + 2 + W);
    push(1'b0, 16'h0002, 16'h0000, 16'h2222, start + 2 + W + 3 + W);
    cycle();
    cycle();
    addr_in = 16'h0002;
    for (int k = 0; k < 20 && cyc < start + 4 + W; k++) cycle();
    req = 1'b0;
    wait_idle();
    chk("b2b_ready_gap", 32'(rdy_last_cyc - rdy_prev_cyc), 32'(3 + W));
    idle_checks(16'h0002);

    // Reset during the first ACCESS cycle of a write.
    req = 1'b1; rw = 1'b1; addr_in = 16'h0030; data_in = 16'h7777;
    cycle();
    req = 1'b0;
    cycle();
    chk("pre_rst_we_low", 32'(we), 32'd0);
    rst_b = 1'b0;
    cycle();
    chk("rst_dout_cleared", 32'(data_out), 32'h0000);
    chk("rst_addr_cleared", 32'(addr), 32'h0000);
    chk("rst_mem_kept", 32'(mem[16'h0030]), 32'h3030);
    idle_checks(16'h0000);
    rst_b = 1'b1;
    do_access(1'b0, 16'h0030, 16'h0000, 16'h3030);

    // I/O region boundary: 0xFDFE is ordinary memory, 0xFFFE is protected when enabled.
    do_access(1'b1, 16'hFDFE, 16'hA0A0, 16'hA0A0);
    do_access(1'b1, 16'hFFFE, 16'h5555, PROT_EN ? 16'hCAFE : 16'h5555);
    do_access(1'b0, 16'hFFFE, 16'h0000, PROT_EN ? 16'hCAFE : 16'h5555);

    for (int i = 0; i < 5; i++) begin
      wd[i] = 16'($urandom);
      ra = 16'h0100 + 16'(i * 7);
      do_access(1'b1, ra, wd[i], wd[i]);
    end
    for (int i = 0; i < 5; i++) begin
      ra = 16'h0100 + 16'(i * 7);
      do_access(1'b0, ra, 16'h0000, wd[i]);
    end

    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL expose parameter WAIT_CYCLES, default 2, meaning the number of ACCESS-state cycles per transfer (legal 1..15).
REQ-002 The block SHALL have port Clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-low reset, sampled only on rising Clk.
REQ-004 The block SHALL have port Req  input  1  access request from the processor control unit, sampled only in IDLE.
REQ-005 The block SHALL have port RW  input  1  access type: 1 = write, 0 = read.
REQ-006 The block SHALL have port Addr_in  input  16  word address (MAR value).
REQ-007 The block SHALL have port Data_in  input  16  write data (MDR value).
REQ-008 The block SHALL have port Data_out  output  16  last completed read data, loaded into the MDR.
REQ-009 The block SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port Busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port ADDR  output  16  SRAM address.
REQ-012 The block SHALL have port Data_Mem  inout  16  SRAM data bus.
REQ-013 The block SHALL have ports CE, UB, LB, OE, WE  output  1 each  active-low SRAM strobes.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, ACCESS, DONE.
REQ-015 IDLE with Req=1 SHALL capture Addr_in, Data_in and RW into internal registers and go to SETUP; with Req=0 it SHALL stay in IDLE.
REQ-016 Changes on Req, RW, Addr_in or Data_in outside IDLE SHALL have no effect.
REQ-017 SETUP SHALL last one cycle: CE=UB=LB=0, ADDR=captured address, OE=0 for a read, WE=1; it SHALL load the wait counter with WAIT_CYCLES-1, then go to ACCESS.
REQ-018 ACCESS SHALL hold CE=UB=LB=0, with OE=0 for a read or WE=0 for a write; the counter SHALL decrement each cycle; the state SHALL go to DONE when the counter equals 0.
REQ-019 A read SHALL register Data_Mem into Data_out at the clock edge that ends the last ACCESS cycle.
REQ-020 DONE SHALL last one cycle with Ready=1, CE=OE=WE=1, and ADDR held; it SHALL always go to IDLE.
REQ-021 Latency: with Req sampled at edge 0, Ready SHALL be high during cycle 2+WAIT_CYCLES; Req held high SHALL give back-to-back accesses every 3+WAIT_CYCLES cycles.
REQ-022 Data_Mem SHALL be driven with the captured write data only in SETUP, ACCESS and DONE of a write, and SHALL be high-Z otherwise.
REQ-023 Data_out SHALL change only on read completion; writes SHALL leave it unchanged.
REQ-024 In IDLE: CE=UB=LB=OE=WE=1, Ready=0, Busy=0, and ADDR SHALL hold its last value.

Reset
REQ-025 Reset=0 at a rising edge SHALL force IDLE, Data_out=0x0000, ADDR=0x0000, all strobes=1, Ready=0, Busy=0, counter=0, and Data_Mem high-Z, from any state.
REQ-026 An access interrupted by reset SHALL be abandoned: no Ready pulse and no Data_out update.
REQ-027 A Req present on the first edge after reset release SHALL be accepted normally.

Configuration
REQ-028 Macro MEM_WRITE_PROTECT_EN, when defined, SHALL make writes with Addr_in[15:9]=7'h7F (0xFE00-0xFFFF, the I/O region) run the full FSM with unchanged latency and Ready pulse, but keep WE=1 and Data_Mem high-Z throughout.
REQ-029 When MEM_WRITE_PROTECT_EN is undefined, all writes SHALL be performed identically regardless of address.

Verification (WAIT_CYCLES=2)
REQ-030 Read: Req=1, RW=0, Addr_in=0x0010, SRAM returns 0x1234 -> OE low 3 cycles (SETUP+2 ACCESS), Ready high in cycle 4, Data_out=0x1234.
REQ-031 Write: Req=1, RW=1, Addr_in=0x0020, Data_in=0xBEEF -> WE low exactly 2 cycles, Data_Mem=0xBEEF during SETUP..DONE, SRAM word 0x0020=0xBEEF, Data_out unchanged.
REQ-032 Back-to-back: Req held high for reads at 0x0001 then 0x0002 -> Ready pulses exactly 5 cycles apart; Addr_in changed during ACCESS is ignored.
REQ-033 Reset=0 asserted during the first ACCESS cycle of a write to 0x0030 -> next cycle IDLE, WE=1, bus high-Z, no Ready, memory unchanged.
REQ-034 Write to 0xFFFE with data 0x5555 -> with MEM_WRITE_PROTECT_EN: Ready in cycle 4, WE never low, memory unchanged; without the macro: memory 0xFFFE=0x5555.
